// File: rtl/ihp_sram_req_adapter.sv
// Fabric request front end for the IHP 1024x32 SRAM tile.
// Maps a valid/ready request stream onto the single-cycle macro pins.
// Read data comes back through a 2-entry response FIFO.
// The array can optionally be zero-filled after each configured rise.
module ihp_sram_req_adapter #(
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned CLEAR_ON_CONFIG = 1
) (
    input  logic                UserCLK,
    input  logic                RST,
    input  logic                CONFIGURED_top,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   A_ADDR,
    output logic [DATA_W-1:0]   A_DIN,
    output logic [DATA_W-1:0]   A_BM,
    output logic                A_WEN,
    output logic                A_MEN,
    output logic                A_REN,
    input  logic [DATA_W-1:0]   A_DOUT
);

    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_UNCONF,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pend;
    logic [DATA_W-1:0]   r_buf [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_cnt_buf;
    logic                w_pop;
    logic                w_push;
    logic                w_rd_credit;
    logic                w_rd_acc;
    logic [DATA_W-1:0]   w_bm;

    // Response handshake and read credit: buffered + in-flight - leaving must stay below 2
    assign w_pop       = (r_cnt_buf != 2'd0) && rsp_ready;
    assign w_push      = r_pend;
    assign w_rd_credit = (3'({1'b0, r_cnt_buf}) + 3'(r_pend) - 3'(w_pop)) < 3'd2;
    assign w_rd_acc    = (r_state == ST_RUN) && req_valid && !req_we && w_rd_credit;

    assign rsp_valid = (r_cnt_buf != 2'd0);
    assign rsp_rdata = r_buf[r_rptr];
    assign busy      = (r_state != ST_RUN);

    // Expand byte enables into a per-bit write mask
    always_comb begin
        w_bm = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            w_bm[i] = req_be[i/8];
        end
    end

    // State register
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_UNCONF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, request acceptance and SRAM pin drive
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        A_ADDR      = '0;
        A_DIN       = '0;
        A_BM        = '0;
        A_WEN       = 1'b0;
        A_MEN       = 1'b0;
        A_REN       = 1'b0;
        case (r_state)
            ST_UNCONF: begin
                if (CONFIGURED_top) begin
                    w_state_nxt = (CLEAR_ON_CONFIG != 0) ? ST_CLEAR : ST_RUN;
                end
            end
            ST_CLEAR: begin
                A_MEN  = 1'b1;
                A_WEN  = 1'b1;
                A_ADDR = ADDR_W'(r_cnt);
                A_BM   = '1;
                if (r_cnt == CNT_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = req_we || w_rd_credit;
                if (req_valid && req_we) begin
                    A_MEN  = 1'b1;
                    A_WEN  = 1'b1;
                    A_ADDR = req_addr;
                    A_DIN  = req_wdata;
                    A_BM   = w_bm;
                end else if (w_rd_acc) begin
                    A_MEN  = 1'b1;
                    A_REN  = 1'b1;
                    A_ADDR = req_addr;
                end
            end
            default: w_state_nxt = ST_UNCONF;
        endcase
        if (!CONFIGURED_top) begin
            w_state_nxt = ST_UNCONF;
        end
    end

    // Clear address counter; any exit from CLEAR rewinds it to 0
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if ((r_state == ST_CLEAR) && (w_state_nxt == ST_CLEAR)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Read in flight: A_DOUT is captured on the following edge regardless of state
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_rd_acc;
        end
    end

    // Two-entry response FIFO
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt_buf <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= A_DOUT;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt_buf <= r_cnt_buf + 2'(w_push) - 2'(w_pop);
        end
    end

    // The read credit must never let a push land on a full FIFO
    a_no_overflow: assert property (@(posedge UserCLK) disable iff (RST)
        !(w_push && !w_pop && (r_cnt_buf == 2'd2)));

endmodule

// File: tb/tb_ihp_sram_req_adapter.sv
// Self-checking bench for ihp_sram_req_adapter with a behavioural SRAM and a
// transaction-level reference (expected memory image plus response queue).
module tb_ihp_sram_req_adapter;

    localparam int DEPTH = 1024;

    logic        UserCLK;
    logic        RST;
    logic        CONFIGURED_top;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [9:0]  A_ADDR;
    logic [31:0] A_DIN;
    logic [31:0] A_BM;
    logic        A_WEN;
    logic        A_MEN;
    logic        A_REN;
    logic [31:0] A_DOUT;

    ihp_sram_req_adapter #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(DEPTH), .CLEAR_ON_CONFIG(1)
    ) dut (
        .UserCLK(UserCLK), .RST(RST), .CONFIGURED_top(CONFIGURED_top),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BM(A_BM),
        .A_WEN(A_WEN), .A_MEN(A_MEN), .A_REN(A_REN), .A_DOUT(A_DOUT)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    // Behavioural SRAM macro: inputs sampled on the rising edge, data next cycle
    logic [31:0] sram [DEPTH];
    always @(posedge UserCLK) begin
        if (A_MEN) begin
            if (A_WEN) sram[A_ADDR] <= (sram[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
            if (A_REN) A_DOUT <= sram[A_ADDR];
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] q[$];
    bit          inflight = 1'b0;
    bit          run_mode = 1'b0;
    bit          last_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // One clock of model bookkeeping; called at the falling edge with inputs set
    task automatic cycle();
        int          buffered;
        bit          exp_pop;
        bit          acc;
        bit          nxt_inflight;
        logic [31:0] m;
        #1;
        buffered = q.size() - int'(inflight);
        check("rsp_valid", 64'(rsp_valid), 64'(buffered > 0));
        exp_pop = (buffered > 0) && rsp_ready;
        if (exp_pop) check("rsp_rdata", 64'(rsp_rdata), 64'(q[0]));
        if (run_mode) begin
            if (req_we) check("wr_ready", 64'(req_ready), 64'd1);
            else check("rd_ready", 64'(req_ready),
                       64'((buffered + int'(inflight) - int'(exp_pop)) < 2));
        end
        if (exp_pop) void'(q.pop_front());
        acc = req_valid && req_ready;
        nxt_inflight = 1'b0;
        if (acc && req_we) begin
            m = be_mask(req_be);
            check("wr_ctl", 64'({A_MEN, A_WEN, A_REN, A_ADDR}), 64'({3'b110, req_addr}));
            check("wr_dat", {A_BM, A_DIN}, {m, req_wdata});
            exp_mem[req_addr] = (exp_mem[req_addr] & ~m) | (req_wdata & m);
        end else if (acc) begin
            check("rd_ctl", 64'({A_MEN, A_WEN, A_REN, A_ADDR}), 64'({3'b101, req_addr}));
            q.push_back(exp_mem[req_addr]);
            nxt_inflight = 1'b1;
        end else if (run_mode) begin
            check("idle", 64'({A_MEN, A_WEN, A_REN}), 64'd0);
        end
        last_acc = acc;
        @(posedge UserCLK);
        inflight = nxt_inflight;
        @(negedge UserCLK);
    endtask

    task automatic do_req(input bit we, input logic [9:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        bit done = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_be = be;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = last_acc;
        end
        if (!done) check("req_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic read_expect(input logic [9:0] addr, input logic [31:0] expv);
        rsp_ready = 1'b1;
        do_req(1'b0, addr, 32'h0, 4'h0);
        cycle();
        #1;
        check("rd_exp", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, expv}));
        cycle();
    endtask

    // Walks a full clear sequence starting at its first cycle
    task automatic clear_check();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("clr_ctl", 64'({busy, A_MEN, A_WEN, A_REN, A_ADDR}), 64'({4'b1110, 10'(i)}));
            check("clr_dat", {A_DIN, ~A_BM}, 64'd0);
            @(posedge UserCLK);
            @(negedge UserCLK);
        end
        #1;
        check("clr_done", 64'({busy, req_ready}), 64'({1'b0, 1'b1}));
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) sram[i] = $urandom | 32'h1;
        A_DOUT = 32'h0;
        RST = 1'b1; CONFIGURED_top = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge UserCLK);
        @(negedge UserCLK); #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_rdata}), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_men", 64'(A_MEN), 64'd0);
        RST = 1'b0;
        cycle();
        check("unconf_busy", 64'({busy, req_ready}), 64'({1'b1, 1'b0}));

        // Configure and zero-fill
        CONFIGURED_top = 1'b1;
        @(posedge UserCLK); @(negedge UserCLK);
        clear_check();
        run_mode = 1'b1;
        read_expect(10'h3FF, 32'h0);

        // Byte-masked write
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5;
        req_wdata = 32'hAABBCCDD; req_be = 4'b0101;
        #1;
        check("bm_mask", 64'({req_ready, A_BM}), 64'({1'b1, 32'h00FF00FF}));
        do_req(1'b1, 10'd5, 32'hAABBCCDD, 4'b0101);
        read_expect(10'd5, 32'h00BB00DD);

        // Back-to-back reads with the consumer always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 10'(i);
            cycle();
            check("b2b_acc", 64'(last_acc), 64'd1);
        end
        req_valid = 1'b0;
        drain();

        // Backpressure: two reads fit, writes still flow
        rsp_ready = 1'b0; n = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n += int'(last_acc);
        end
        check("bp_acc", 64'(n), 64'd2);
        req_we = 1'b1; req_addr = 10'd9; req_wdata = 32'h12345678; req_be = 4'hF;
        cycle();
        check("bp_wr", 64'(last_acc), 64'd1);
        req_valid = 1'b0;
        drain();

        // Randomized traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = 10'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 1'b0;
        drain();

        // Configured drop in the middle of a clear, then a full restart
        CONFIGURED_top = 1'b0; run_mode = 1'b0;
        cycle(); cycle();
        CONFIGURED_top = 1'b1;
        cycle();
        for (int i = 0; i <= 300; i++) begin
            #1;
            check("pclr_ctl", 64'({busy, A_MEN, A_WEN, A_ADDR}), 64'({3'b111, 10'(i)}));
            if (i == 300) CONFIGURED_top = 1'b0;
            @(posedge UserCLK); @(negedge UserCLK);
        end
        #1;
        check("drop_men", 64'({A_MEN, busy}), 64'({1'b0, 1'b1}));
        CONFIGURED_top = 1'b1;
        @(posedge UserCLK); @(negedge UserCLK);
        clear_check();
        run_mode = 1'b1;
        do_req(1'b1, 10'd2, 32'hCAFEF00D, 4'hF);
        read_expect(10'd2, 32'hCAFEF00D);

        // Reset while a read is in flight
        rsp_ready = 1'b1;
        do_req(1'b0, 10'd2, 32'h0, 4'h0);
        RST = 1'b1;
        #1;
        check("rst_fl_rv", 64'(rsp_valid), 64'd0);
        check("rst_fl_st", 64'({req_ready, busy}), 64'({1'b0, 1'b1}));
        @(posedge UserCLK); @(negedge UserCLK); #1;
        check("rst_fl_push", 64'({rsp_valid, rsp_rdata}), 64'd0);
        q.delete(); inflight = 1'b0; run_mode = 1'b0;
        RST = 1'b0;
        @(posedge UserCLK); @(negedge UserCLK); #1;
        check("rst_rel", 64'({rsp_valid, busy}), 64'({1'b0, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
